mdu_ex_unit: RTL
================

Name: mdu_ex_unit

Overview:
Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline; owns architectural HI/LO.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from ID/EX and provides HI/LO read data to the EX/MEM pipeline register.
- Its stall output drives the hazard unit, which deasserts the pipeline-register enables and inserts bubbles while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range >=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range >=1)

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
start  in  1  valid MDU op in EX this cycle
op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no-op)
a  in  32  rs operand (forwarded)
b  in  32  rt operand (forwarded)
busy  out  1  registered; high while a mult/div is in flight
stall  out  1  combinational: busy | (start & op in 0..3)
hi  out  32  current HI
lo  out  32  current LO

Behaviour:
- Reset, asynchronous on reset==0: state IDLE, counter 0, busy 0, hi 0, lo 0, pending results 0. Reset mid-operation abandons the op; HI/LO return to 0.
- States:
  - IDLE
  - BUSY
- IDLE, start, op 0-3 (edge k):
  - Compute the full result from a, b as sampled at edge k into pending_hi/pending_lo.
  - Load counter with N-1; N=MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY; busy=1 from cycle k+1.
- BUSY:
  - Counter decrements each edge.
  - At the edge where the counter is 0, commit pending_hi/lo to hi/lo, busy->0, go to IDLE.
  - busy is therefore high for exactly N cycles.
  - New hi/lo are visible in the same cycle busy falls.
- IDLE, start, op 4 or 5: write a to hi (MTHI) or lo (MTLO) at that edge; no busy.
- start while BUSY: ignored. The hazard unit guarantees no MDU op or mfhi/mflo issues while stall=1; a bench may check that hi/lo and pending are undisturbed.
- Reserved op with start: no state change, stall 0.
- Arithmetic:
  - MULT: signed 32x32->64, hi=upper, lo=lower. MULTU: unsigned.
  - DIV/DIVU: lo=quotient, hi=remainder; signed truncates toward zero, remainder takes the sign of the dividend.
- Divide by zero (DIV/DIVU): lo=32'hFFFFFFFF, hi=a.
- Signed overflow DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- hi/lo change only on commit, MTHI/MTLO, or reset.

Optional Feature:
MDU_CANCEL_EN:
- Defined: adds input cancel (1 bit). cancel=1 at an edge while BUSY returns to IDLE with busy=0 and no commit; hi/lo are unchanged. cancel=1 in the same cycle as start (IDLE) suppresses the start, including MTHI/MTLO. Used for exception flush.
- Undefined: port absent; every accepted op completes.

Decomposition:
- Package mdu_pkg:
  - op encodings MDU_MULT..MDU_MTLO
  - state enum {IDLE, BUSY}
  - result width constant 64
- Sub-module mdu_calc: purely combinational 64-bit result from op/a/b, including div-by-zero and overflow rules.
- mdu_ex_unit holds the FSM, counter, pending and HI/LO registers.

Test Plan:
- Reset low then high; start MULT a=32'hFFFFFFFF (-1), b=2 -> stall=1 in the start cycle; busy high exactly 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFFE.
- MULTU a=32'hFFFFFFFF, b=2 -> hi=1, lo=32'hFFFFFFFE after 5 cycles.
- DIV a=-7 (32'hFFFFFFF9), b=2 -> busy 10 cycles; lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. Then DIVU a=7, b=0 -> lo=32'hFFFFFFFF, hi=7.
- MTHI a=32'h12345678 while IDLE -> hi updated next edge, busy stays 0. Then start MTLO while BUSY on a MULT -> lo equals MULT result, not the MTLO operand.
- Start DIV 32'h80000000/32'hFFFFFFFF, drop reset at cycle 3 of busy -> busy=0, hi=lo=0 immediately and after release.
- With MDU_CANCEL_EN: MULT 3x4 then cancel at busy cycle 2 -> busy=0 next cycle; hi/lo keep prior values (0/0).

Source files
------------

// File: rtl/mdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_pkg: shared op encodings, FSM states and widths for the MDU.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mdu_pkg;

  localparam int RESULT_W = 64;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

  // Multiply/divide ops occupy encodings 0..3.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_calc: combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]          op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  output logic [RESULT_W-1:0] result
);

  logic        w_signed_div;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_dividend;
  logic [31:0] w_divisor;
  logic [31:0] w_quot_mag;
  logic [31:0] w_rem_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign w_prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  // One unsigned divider on magnitudes; the divisor is forced nonzero so the
  // datapath never divides by zero, the zero case is substituted below.
  assign w_signed_div = (op == MDU_DIV);
  assign w_a_neg      = w_signed_div & a[31];
  assign w_b_neg      = w_signed_div & b[31];
  assign w_dividend   = w_a_neg ? (32'd0 - a) : a;
  assign w_divisor    = (b == 32'd0) ? 32'd1 : (w_b_neg ? (32'd0 - b) : b);
  assign w_quot_mag   = w_dividend / w_divisor;
  assign w_rem_mag    = w_dividend % w_divisor;
  // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
  assign w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_quot_mag) : w_quot_mag;
  assign w_rem        = w_a_neg ? (32'd0 - w_rem_mag) : w_rem_mag;

  always_comb begin
    result = '0;
    case (op)
      MDU_MULT:  result = w_prod_s;
      MDU_MULTU: result = w_prod_u;
      MDU_DIV, MDU_DIVU: begin
        if (b == 32'd0) result = {a, 32'hFFFF_FFFF};
        else            result = {w_rem, w_quot};
      end
      default:   result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu_ex_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_ex_unit: multi-cycle EX-stage mult/div unit owning HI/LO.        |
// | Optional flush input enabled by MDU_CANCEL_EN. Revision: 1.0         |
// +----------------------------------------------------------------------+
module mdu_ex_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_state_t          r_state;
  mdu_state_t          w_next_state;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_next_count;
  logic [RESULT_W-1:0] r_pending;
  logic [RESULT_W-1:0] w_next_pending;
  logic [31:0]         r_hi;
  logic [31:0]         w_next_hi;
  logic [31:0]         r_lo;
  logic [31:0]         w_next_lo;
  logic [RESULT_W-1:0] w_calc;
  logic                w_cancel;

`ifdef MDU_CANCEL_EN
  assign w_cancel = cancel;
`else
  assign w_cancel = 1'b0;
`endif

  mdu_calc u_calc (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (w_calc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_pending <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_next_state;
      r_count   <= w_next_count;
      r_pending <= w_next_pending;
      r_hi      <= w_next_hi;
      r_lo      <= w_next_lo;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_count   = r_count;
    w_next_pending = r_pending;
    w_next_hi      = r_hi;
    w_next_lo      = r_lo;
    case (r_state)
      IDLE: begin
        if (start && !w_cancel) begin
          if (is_muldiv(op)) begin
            w_next_pending = w_calc;
            w_next_count   = op[1] ? DIV_LOAD : MULT_LOAD;
            w_next_state   = BUSY;
          end else if (op == MDU_MTHI) begin
            w_next_hi = a;
          end else if (op == MDU_MTLO) begin
            w_next_lo = a;
          end
        end
      end
      BUSY: begin
        // Any start seen here is ignored; the hazard unit holds issue off.
        if (w_cancel) begin
          w_next_state = IDLE;
        end else if (r_count == '0) begin
          w_next_hi    = r_pending[63:32];
          w_next_lo    = r_pending[31:0];
          w_next_state = IDLE;
        end else begin
          w_next_count = r_count - 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign busy  = (r_state == BUSY);
  assign stall = busy | (start & is_muldiv(op));
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule
`default_nettype wire
